// File: rtl/stim_check_pkg.sv
// Shared types and helpers for the stimulus generator / output checker.
package stim_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DUT_RESET = 3'd1,
        ST_RUN       = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'b00,
        MODE_LFSR  = 2'b01,
        MODE_WALK  = 2'b10,
        MODE_CONST = 2'b11
    } mode_t;

    // Galois feedback taps for the supported data widths
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            default: return 32'h8020_0003;
        endcase
    endfunction

    // One right-shift Galois step; the value is zero-extended into 32 bits
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur, input int width);
        logic [31:0] nxt;
        nxt = cur >> 1;
        if (cur[0])
            nxt = nxt ^ lfsr_taps(width);
        return nxt;
    endfunction

endpackage

// File: rtl/stim_delay_line.sv
// Fixed-depth register chain aligning expected data/index/valid with the DUT output.
module stim_delay_line
    import stim_check_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_p [DEPTH];

    // Shift the word one stage per cycle; reset flushes every stage so no stale valid escapes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                pipe_p[i] <= '0;
        end else begin
            pipe_p[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                pipe_p[i] <= pipe_p[i-1];
        end
    end

    assign dout = pipe_p[DEPTH-1];

endmodule

// File: rtl/stim_check_gen.sv
// Stimulus generator and latency-aligned output checker for pass-through datapaths.
module stim_check_gen
    import stim_check_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_VEC  = 256,
    parameter int RST_HOLD = 4,
    parameter int LATENCY  = 1,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] SEED,
    output logic             DUT_RST,
    output logic [WIDTH-1:0] STIM_DATA,
    output logic             STIM_VALID,
    input  logic [WIDTH-1:0] OUTPUT_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             MISMATCH,
    output logic [CNT_W-1:0] ERR_COUNT,
    output logic [CNT_W-1:0] FIRST_ERR_IDX
);

    localparam int              DL_W       = WIDTH + CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [3:0]       DRAIN_LAST = 4'(LATENCY - 1);

    state_t           state;
    mode_t            mode_q;
    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] vec_idx;
    logic [CNT_W-1:0] hold_cnt;
    logic [3:0]       drain_cnt;
    logic             err_seen;

    logic [DL_W-1:0]  dl_in;
    logic [DL_W-1:0]  dl_out;
    logic             vld_p1;
    logic [CNT_W-1:0] idx_p1;
    logic [WIDTH-1:0] exp_p1;
    logic             cmp_fail;
    logic [CNT_W-1:0] err_next;

    // First vector of a run for the latched mode and seed
    function automatic logic [WIDTH-1:0] first_vec(input mode_t m, input logic [WIDTH-1:0] seed);
        case (m)
            MODE_LFSR: return (seed == '0) ? '1 : seed;
            MODE_WALK: return WIDTH'(1);
            default:   return seed;
        endcase
    endfunction

    // Successor of the current vector for the latched mode
    function automatic logic [WIDTH-1:0] next_vec(input mode_t m, input logic [WIDTH-1:0] cur);
        logic [31:0] lfsr_wide;
        lfsr_wide = lfsr_next(32'(cur), WIDTH);
        case (m)
            MODE_COUNT: return cur + WIDTH'(1);
            MODE_LFSR:  return WIDTH'(lfsr_wide);
            MODE_WALK:  return {cur[WIDTH-2:0], cur[WIDTH-1]};
            default:    return cur;
        endcase
    endfunction

    assign dl_in = {STIM_VALID, vec_idx, STIM_DATA};

    stim_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk   (CLK),
        .rst_n (RST),
        .din   (dl_in),
        .dout  (dl_out)
    );

    assign {vld_p1, idx_p1, exp_p1} = dl_out;

    // Compare only live delayed vectors; the error count saturates at all-ones
    always_comb begin
        cmp_fail = vld_p1 && (OUTPUT_DATA != exp_p1);
        err_next = ERR_COUNT;
        if (cmp_fail && (ERR_COUNT != CNT_MAX))
            err_next = ERR_COUNT + CNT_W'(1);
    end

    // Run sequencer with registered stimulus, status and error statistics
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_COUNT;
            seed_q        <= '0;
            vec_idx       <= '0;
            hold_cnt      <= '0;
            drain_cnt     <= '0;
            err_seen      <= 1'b0;
            DUT_RST       <= 1'b0;
            STIM_DATA     <= '0;
            STIM_VALID    <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            PASS          <= 1'b0;
            MISMATCH      <= 1'b0;
            ERR_COUNT     <= '0;
            FIRST_ERR_IDX <= '1;
        end else begin
            MISMATCH  <= cmp_fail;
            ERR_COUNT <= err_next;
            if (cmp_fail && !err_seen) begin
                err_seen      <= 1'b1;
                FIRST_ERR_IDX <= idx_p1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        mode_q        <= mode_t'(MODE);
                        seed_q        <= SEED;
                        hold_cnt      <= '0;
                        err_seen      <= 1'b0;
                        ERR_COUNT     <= '0;
                        FIRST_ERR_IDX <= '1;
                        DUT_RST       <= 1'b0;
                        BUSY          <= 1'b1;
                        DONE          <= 1'b0;
                        PASS          <= 1'b0;
                        state         <= ST_DUT_RESET;
                    end
                end
                ST_DUT_RESET: begin
                    if (hold_cnt == HOLD_LAST) begin
                        DUT_RST    <= 1'b1;
                        STIM_VALID <= 1'b1;
                        STIM_DATA  <= first_vec(mode_q, seed_q);
                        vec_idx    <= '0;
                        state      <= ST_RUN;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (vec_idx == LAST_IDX) begin
                        STIM_VALID <= 1'b0;
                        drain_cnt  <= '0;
                        state      <= ST_DRAIN;
                    end else begin
                        vec_idx   <= vec_idx + CNT_W'(1);
                        STIM_DATA <= next_vec(mode_q, STIM_DATA);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= (err_next == '0);
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stim_check_gen.sv
// Directed bench for stim_check_gen with register loopbacks standing in for the DUT.
module tb_stim_check_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance A: 16-bit, 8 vectors, latency 1 ----------------
    logic        a_start = 1'b0;
    logic [1:0]  a_mode = 2'b00;
    logic [15:0] a_seed = 16'h0;
    logic        a_dut_rst, a_valid, a_busy, a_done, a_pass, a_mm;
    logic [15:0] a_stim, a_q, a_err, a_fidx;
    logic        a_inject = 1'b0;
    int          a_vcnt = 0;
    logic [15:0] a_vecs[$];

    stim_check_gen #(.WIDTH(16), .NUM_VEC(8), .RST_HOLD(4), .LATENCY(1), .CNT_W(16)) u_a (
        .CLK(clk), .RST(rst_n), .START(a_start), .MODE(a_mode), .SEED(a_seed),
        .DUT_RST(a_dut_rst), .STIM_DATA(a_stim), .STIM_VALID(a_valid), .OUTPUT_DATA(a_q),
        .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .MISMATCH(a_mm),
        .ERR_COUNT(a_err), .FIRST_ERR_IDX(a_fidx));

    always @(posedge clk) begin
        if (!a_busy) a_vcnt <= 0;
        else if (a_valid) a_vcnt <= a_vcnt + 1;
        a_q <= a_stim ^ ((a_inject && a_valid && a_vcnt == 2) ? 16'h0001 : 16'h0000);
    end

    // ---------------- instance W: 16-bit walking-one, 18 vectors, latency 3 ----------------
    logic        w_start = 1'b0;
    logic [1:0]  w_mode = 2'b10;
    logic [15:0] w_seed = 16'h1234;
    logic        w_dut_rst, w_valid, w_busy, w_done, w_pass, w_mm;
    logic [15:0] w_stim, w_q1, w_q2, w_q3, w_err, w_fidx;
    logic [15:0] w_vecs[$];

    stim_check_gen #(.WIDTH(16), .NUM_VEC(18), .RST_HOLD(2), .LATENCY(3), .CNT_W(16)) u_w (
        .CLK(clk), .RST(rst_n), .START(w_start), .MODE(w_mode), .SEED(w_seed),
        .DUT_RST(w_dut_rst), .STIM_DATA(w_stim), .STIM_VALID(w_valid), .OUTPUT_DATA(w_q3),
        .BUSY(w_busy), .DONE(w_done), .PASS(w_pass), .MISMATCH(w_mm),
        .ERR_COUNT(w_err), .FIRST_ERR_IDX(w_fidx));

    always @(posedge clk) begin
        w_q1 <= w_stim;
        w_q2 <= w_q1;
        w_q3 <= w_q2;
    end

    // ---------------- instance L: 8-bit LFSR, 255 vectors, latency 1 ----------------
    logic        l_start = 1'b0;
    logic [1:0]  l_mode = 2'b01;
    logic [7:0]  l_seed = 8'h00;
    logic        l_dut_rst, l_valid, l_busy, l_done, l_pass, l_mm;
    logic [7:0]  l_stim, l_q, l_err, l_fidx;
    logic [7:0]  l_vecs[$];

    stim_check_gen #(.WIDTH(8), .NUM_VEC(255), .RST_HOLD(1), .LATENCY(1), .CNT_W(8)) u_l (
        .CLK(clk), .RST(rst_n), .START(l_start), .MODE(l_mode), .SEED(l_seed),
        .DUT_RST(l_dut_rst), .STIM_DATA(l_stim), .STIM_VALID(l_valid), .OUTPUT_DATA(l_q),
        .BUSY(l_busy), .DONE(l_done), .PASS(l_pass), .MISMATCH(l_mm),
        .ERR_COUNT(l_err), .FIRST_ERR_IDX(l_fidx));

    always @(posedge clk) l_q <= l_stim;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a run on A and watch it until DONE; k counts rising edges after the accepting edge
    task automatic run_a(input logic [1:0] mode, input logic [15:0] seed, input int pulse_at,
                         output int done_k, output int low_cyc, output int mm_pulses,
                         output logic [15:0] err0, output logic [15:0] fidx0, output logic done0);
        a_vecs.delete();
        done_k = -1; low_cyc = 0; mm_pulses = 0;
        err0 = '0; fidx0 = '0; done0 = 1'b0;
        @(negedge clk);
        a_mode = mode; a_seed = seed; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            a_start = (k == pulse_at);
            if (k == 0) begin err0 = a_err; fidx0 = a_fidx; done0 = a_done; end
            if (a_busy && !a_dut_rst) low_cyc++;
            if (a_mm) mm_pulses++;
            if (a_valid) a_vecs.push_back(a_stim);
            if (a_done) begin done_k = k; break; end
            @(negedge clk);
        end
        a_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_k, low_cyc, mm_p;
        logic [15:0] err0, fidx0;
        logic done0;
        logic [15:0] wexp;
        logic [7:0] lv;
        logic seen [256];
        int repeats;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dut_rst", a_dut_rst, 0);
        check("rst_stim", a_stim, 16'h0);
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done_pass", {a_done, a_pass, a_mm}, 3'b000);
        check("rst_err", a_err, 0);
        check("rst_fidx", a_fidx, 16'hFFFF);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_dut_rst", a_dut_rst, 0);

        // Clean count-up run wrapping through zero
        run_a(2'b00, 16'hFFFE, -1, done_k, low_cyc, mm_p, err0, fidx0, done0);
        check("cnt_done_k", done_k, 13);
        check("cnt_rst_low", low_cyc, 4);
        check("cnt_nvec", a_vecs.size(), 8);
        for (int i = 0; i < 8 && i < a_vecs.size(); i++)
            check($sformatf("cnt_vec%0d", i), a_vecs[i], 16'(16'hFFFE + i));
        check("cnt_pass", a_pass, 1);
        check("cnt_err", a_err, 0);
        check("cnt_fidx", a_fidx, 16'hFFFF);
        check("cnt_mm", mm_p, 0);
        check("cnt_dut_rst_hi", a_dut_rst, 1);

        // Same run with bit 0 of vector 2 corrupted
        a_inject = 1'b1;
        run_a(2'b00, 16'hFFFE, -1, done_k, low_cyc, mm_p, err0, fidx0, done0);
        a_inject = 1'b0;
        check("inj_mm_pulses", mm_p, 1);
        check("inj_err", a_err, 1);
        check("inj_fidx", a_fidx, 2);
        check("inj_pass", a_pass, 0);
        check("inj_done_k", done_k, 13);

        // Restart from DONE in constant mode
        run_a(2'b11, 16'hA5A5, -1, done_k, low_cyc, mm_p, err0, fidx0, done0);
        check("rs_err_clear", err0, 0);
        check("rs_fidx_clear", fidx0, 16'hFFFF);
        check("rs_done_low", done0, 0);
        check("rs_rst_low", low_cyc, 4);
        check("rs_nvec", a_vecs.size(), 8);
        for (int i = 0; i < 8 && i < a_vecs.size(); i++)
            check($sformatf("rs_vec%0d", i), a_vecs[i], 16'hA5A5);
        check("rs_pass", a_pass, 1);
        check("rs_err", a_err, 0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a_mode = 2'b00; a_seed = 16'h0100; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (6) @(negedge clk);
        check("mr_in_run", {a_busy, a_valid}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("mr_dut_rst", a_dut_rst, 0);
        check("mr_stim", a_stim, 0);
        check("mr_valid", a_valid, 0);
        check("mr_busy", a_busy, 0);
        check("mr_done_pass_mm", {a_done, a_pass, a_mm}, 3'b000);
        check("mr_err", a_err, 0);
        check("mr_fidx", a_fidx, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mr_stays_idle", {a_busy, a_done}, 2'b00);

        // START pulse during RUN must be ignored
        run_a(2'b00, 16'h0010, 7, done_k, low_cyc, mm_p, err0, fidx0, done0);
        check("ign_done_k", done_k, 13);
        check("ign_nvec", a_vecs.size(), 8);
        for (int i = 0; i < 8 && i < a_vecs.size(); i++)
            check($sformatf("ign_vec%0d", i), a_vecs[i], 16'(16'h0010 + i));
        check("ign_pass", a_pass, 1);

        // Walking-one with wrap, latency 3
        w_vecs.delete();
        done_k = -1;
        @(negedge clk);
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (w_valid) w_vecs.push_back(w_stim);
            if (w_done) begin done_k = k; break; end
            @(negedge clk);
        end
        check("walk_done_k", done_k, 23);
        check("walk_nvec", w_vecs.size(), 18);
        for (int i = 0; i < 18 && i < w_vecs.size(); i++) begin
            wexp = 16'h0001 << (i % 16);
            check($sformatf("walk_vec%0d", i), w_vecs[i], wexp);
        end
        check("walk_pass", w_pass, 1);
        check("walk_err", w_err, 0);

        // LFSR from zero seed, full 255-vector period
        l_vecs.delete();
        done_k = -1;
        @(negedge clk);
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (l_valid) l_vecs.push_back(l_stim);
            if (l_done) begin done_k = k; break; end
            @(negedge clk);
        end
        check("lfsr_done_k", done_k, 257);
        check("lfsr_nvec", l_vecs.size(), 255);
        if (l_vecs.size() >= 2) begin
            check("lfsr_vec0", l_vecs[0], 8'hFF);
            check("lfsr_vec1", l_vecs[1], 8'hC7);
        end
        lv = 8'hFF;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        repeats = 0;
        for (int i = 0; i < l_vecs.size(); i++) begin
            check($sformatf("lfsr_vec%0d", i), l_vecs[i], lv);
            if (seen[l_vecs[i]]) repeats++;
            seen[l_vecs[i]] = 1'b1;
            lv = (lv >> 1) ^ (lv[0] ? 8'hB8 : 8'h00);
        end
        check("lfsr_repeats", repeats, 0);
        check("lfsr_pass", l_pass, 1);
        check("lfsr_err", l_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
